prover_compute_v_early_betafeed: RTL and testbench



---
 rtl/prover_compute_v_early_betafeed_pkg.sv | 42 ++++
 rtl/prover_compute_v_early_betafeed_pairunit.sv | 99 +++++++++
 rtl/prover_compute_v_early_betafeed.sv | 225 ++++++++++++++++++++++
 tb/tb_prover_compute_v_early_betafeed.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prover_compute_v_early_betafeed_pkg.sv
// Shared types and field arithmetic for the early-gates beta feeder.
// Latency: n/a (package). Backpressure: n/a.
// Field is GF(2^61-1); f_mul relies on that Mersenne form for its reduction.
package prover_compute_v_early_betafeed_pkg;

  localparam int F_NBITS = 61;
  localparam logic [F_NBITS-1:0] F_Q = {F_NBITS{1'b1}};

  typedef logic [F_NBITS-1:0] fe_t;

  typedef enum logic [1:0] {ST_IDLE, ST_PTS, ST_WAITR, ST_FOLD} state_t;

  localparam int BEN_EVEN = 0;
  localparam int BEN_ODD  = 1;
  localparam int BEN_PT3  = 2;
  localparam int BEN_PT4  = 3;

  function automatic fe_t f_add(input fe_t a, input fe_t b);
    logic [F_NBITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, F_Q}) s = s - {1'b0, F_Q};
    return s[F_NBITS-1:0];
  endfunction

  // a - b mod F_Q; the wrap branch cannot overflow since a < b.
  function automatic fe_t f_sub(input fe_t a, input fe_t b);
    if (a >= b) return a - b;
    return a + (F_Q - b);
  endfunction

  // 2^61 == 1 mod F_Q, so the high half of the product folds onto the low half.
  function automatic fe_t f_mul(input fe_t a, input fe_t b);
    logic [2*F_NBITS-1:0] p;
    logic [F_NBITS+1:0]   t;
    p = {{F_NBITS{1'b0}}, a} * {{F_NBITS{1'b0}}, b};
    t = {2'b00, p[F_NBITS-1:0]} + {2'b00, p[2*F_NBITS-1:F_NBITS]};
    if (t >= {2'b00, F_Q}) t = t - {2'b00, F_Q};
    if (t >= {2'b00, F_Q}) t = t - {2'b00, F_Q};
    return t[F_NBITS-1:0];
  endfunction

endpackage

// File: rtl/prover_compute_v_early_betafeed_pairunit.sv
// One beta pair through a single adder and multiplier: points (p3,p4) or fold.
// Latency: 4 cycles from accepted i_en to one-cycle o_vld.
// Backpressure: i_en accepted only while o_rdy; i_clr drops any pair in flight.
module prover_betafeed_pairunit
  import prover_compute_v_early_betafeed_pkg::*;
(
  input  logic clk,
  input  logic rstb,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_fold,
  input  fe_t  i_even,
  input  fe_t  i_odd,
  input  fe_t  i_r,
  output logic o_rdy,
  output logic o_vld,
  output fe_t  o_res_a,
  output fe_t  o_res_b
);

  logic       r_busy, r_fold, r_vld;
  logic [1:0] r_step;
  fe_t        r_even, r_odd, r_r, r_d, r_a, r_res_a, r_res_b;
  fe_t        w_x, w_y, w_add, w_prod;
  logic       w_sub;

  // Steer the one adder: step0 d=odd-even, step1 p3=odd+d, step2 p4=p3+d or even+r*d.
  always_comb begin
    w_x   = r_odd;
    w_y   = r_even;
    w_sub = 1'b1;
    case (r_step)
      2'd1: begin
        w_x   = r_odd;
        w_y   = r_d;
        w_sub = 1'b0;
      end
      2'd2: begin
        w_x   = r_fold ? r_even : r_a;
        w_y   = r_fold ? r_a    : r_d;
        w_sub = 1'b0;
      end
      default: ;
    endcase
    w_add  = w_sub ? f_sub(w_x, w_y) : f_add(w_x, w_y);
    w_prod = f_mul(r_r, r_d);
  end

  // Step sequencer; a result is held in r_res_* and flagged for one cycle.
  always_ff @(posedge clk) begin
    if (rstb || i_clr) begin
      r_busy  <= 1'b0;
      r_fold  <= 1'b0;
      r_vld   <= 1'b0;
      r_step  <= 2'd0;
      r_even  <= '0;
      r_odd   <= '0;
      r_r     <= '0;
      r_d     <= '0;
      r_a     <= '0;
      r_res_a <= '0;
      r_res_b <= '0;
    end else begin
      r_vld <= 1'b0;
      if (i_en && !r_busy) begin
        r_busy <= 1'b1;
        r_step <= 2'd0;
        r_fold <= i_fold;
        r_even <= i_even;
        r_odd  <= i_odd;
        r_r    <= i_r;
      end else if (r_busy) begin
        case (r_step)
          2'd0: begin
            r_d    <= w_add;
            r_step <= 2'd1;
          end
          2'd1: begin
            r_a    <= r_fold ? w_prod : w_add;
            r_step <= 2'd2;
          end
          default: begin
            r_res_a <= r_fold ? w_add : r_a;
            r_res_b <= w_add;
            r_vld   <= 1'b1;
            r_busy  <= 1'b0;
            r_step  <= 2'd0;
          end
        endcase
      end
    end
  end

  assign o_rdy   = !r_busy;
  assign o_vld   = r_vld;
  assign o_res_a = r_res_a;
  assign o_res_b = r_res_b;

endmodule

// File: rtl/prover_compute_v_early_betafeed.sv
// Beta table feeder: per copy-bit round emits even/odd/pt3/pt4 vectors, folds on r.
// Latency: ~5 cycles per pair per phase; strobes beta_en once per round.
// Backpressure: none downstream; r_en honoured only in ST_WAITR. Option: BETAFEED_EARLY_EVEN_EN.
module prover_compute_v_early_betafeed
  import prover_compute_v_early_betafeed_pkg::*;
#(
  parameter  int nCopyBits = 3,
  localparam int nCopies   = 1 << nCopyBits,
  localparam int nCopiesH  = 1 << (nCopyBits - 1),
  localparam int RW        = $clog2(nCopyBits + 1)
) (
  input  logic                          clk,
  input  logic                          rstb,
  input  logic                          init_en,
  input  logic [F_NBITS*nCopies-1:0]    beta_init,
  input  logic                          r_en,
  input  logic [F_NBITS-1:0]            r_in,
  output logic [3:0]                    beta_en,
  output logic [F_NBITS*nCopiesH-1:0]   beta_even_out,
  output logic [F_NBITS*nCopiesH-1:0]   beta_odd_out,
  output logic [F_NBITS*nCopiesH-1:0]   point3_out,
  output logic [F_NBITS*nCopiesH-1:0]   point4_out,
  output logic [RW-1:0]                 round,
  output logic                          ready,
  output logic                          done
);

`ifdef BETAFEED_EARLY_EVEN_EN
  localparam bit EARLY_EVEN = 1'b1;
`else
  localparam bit EARLY_EVEN = 1'b0;
`endif
  localparam logic [nCopyBits-1:0] ONE_I   = 1;
  localparam logic [nCopyBits-1:0] NPAIRS0 = nCopyBits'(nCopiesH);
  localparam logic [RW-1:0]        ONE_R   = 1;
  localparam logic [RW-1:0]        LAST_R  = RW'(nCopyBits);

  state_t                       r_state, w_nxt;
  fe_t                          r_tab [nCopies];
  fe_t                          r_p3s [nCopiesH];
  fe_t                          r_p4s [nCopiesH];
  fe_t                          r_r;
  logic [nCopyBits-1:0]         r_idx, r_npairs, w_ie, w_io;
  logic [RW-1:0]                r_round, w_round_nx;
  logic                         r_done, r_issued, r_first;
  logic [3:0]                   r_ben;
  logic [F_NBITS*nCopiesH-1:0]  r_even_out, r_odd_out, r_p3_out, r_p4_out;
  logic                         w_pu_en, w_pu_rdy, w_pu_vld, w_last, w_ready;
  fe_t                          w_res_a, w_res_b;

  // Pair i reads table[2i] and table[2i+1]; fold writes table[i], never ahead of a read.
  assign w_ie       = r_idx << 1;
  assign w_io       = w_ie | ONE_I;
  assign w_last     = (r_idx == (r_npairs - ONE_I));
  assign w_round_nx = r_round + ONE_R;

  prover_betafeed_pairunit u_pair (
    .clk     (clk),
    .rstb    (rstb),
    .i_clr   (init_en),
    .i_en    (w_pu_en),
    .i_fold  (r_state == ST_FOLD),
    .i_even  (r_tab[w_ie]),
    .i_odd   (r_tab[w_io]),
    .i_r     (r_r),
    .o_rdy   (w_pu_rdy),
    .o_vld   (w_pu_vld),
    .o_res_a (w_res_a),
    .o_res_b (w_res_b)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rstb) r_state <= ST_IDLE;
    else      r_state <= w_nxt;
  end

  // Next state, pair issue and ready; init_en overrides everything as a restart.
  always_comb begin
    w_nxt   = r_state;
    w_pu_en = 1'b0;
    w_ready = 1'b0;
    case (r_state)
      ST_IDLE:  w_ready = 1'b1;
      ST_PTS: begin
        // Hold off issue on the first cycle so any early strobe sees an idle unit.
        w_pu_en = !r_issued && !r_first && w_pu_rdy;
        if (w_pu_vld && w_last) w_nxt = ST_WAITR;
      end
      ST_WAITR: begin
        w_ready = 1'b1;
        if (r_en) w_nxt = ST_FOLD;
      end
      ST_FOLD: begin
        w_pu_en = !r_issued && w_pu_rdy;
        if (w_pu_vld && w_last) w_nxt = (w_round_nx == LAST_R) ? ST_IDLE : ST_PTS;
      end
      default: w_nxt = ST_IDLE;
    endcase
    if (init_en) begin
      w_nxt   = ST_PTS;
      w_pu_en = 1'b0;
    end
  end

  // Table, round bookkeeping and output vector latching.
  always_ff @(posedge clk) begin
    if (rstb) begin
      for (int i = 0; i < nCopies; i++) r_tab[i] <= '0;
      for (int i = 0; i < nCopiesH; i++) begin
        r_p3s[i] <= '0;
        r_p4s[i] <= '0;
      end
      r_r        <= '0;
      r_idx      <= '0;
      r_npairs   <= NPAIRS0;
      r_round    <= '0;
      r_done     <= 1'b0;
      r_issued   <= 1'b0;
      r_first    <= 1'b0;
      r_ben      <= 4'b0000;
      r_even_out <= '0;
      r_odd_out  <= '0;
      r_p3_out   <= '0;
      r_p4_out   <= '0;
    end else begin
      r_ben <= 4'b0000;
      if (init_en) begin
        for (int i = 0; i < nCopies; i++) r_tab[i] <= beta_init[i*F_NBITS +: F_NBITS];
        r_idx    <= '0;
        r_npairs <= NPAIRS0;
        r_round  <= '0;
        r_done   <= 1'b0;
        r_issued <= 1'b0;
        r_first  <= 1'b1;
      end else begin
        case (r_state)
          ST_PTS: begin
            if (r_first) begin
              r_first <= 1'b0;
              if (EARLY_EVEN) begin
                for (int i = 0; i < nCopiesH; i++) begin
                  r_even_out[i*F_NBITS +: F_NBITS] <= (i < int'(r_npairs)) ? r_tab[2*i]   : '0;
                  r_odd_out[i*F_NBITS +: F_NBITS]  <= (i < int'(r_npairs)) ? r_tab[2*i+1] : '0;
                end
                r_ben[BEN_EVEN] <= 1'b1;
                r_ben[BEN_ODD]  <= 1'b1;
              end
            end
            if (w_pu_en) r_issued <= 1'b1;
            if (w_pu_vld) begin
              r_issued <= 1'b0;
              for (int i = 0; i < nCopiesH; i++) begin
                if (int'(r_idx) == i) begin
                  r_p3s[i] <= w_res_a;
                  r_p4s[i] <= w_res_b;
                end
              end
              if (w_last) begin
                r_idx <= '0;
                for (int i = 0; i < nCopiesH; i++) begin
                  if (i < int'(r_npairs)) begin
                    r_p3_out[i*F_NBITS +: F_NBITS] <= (int'(r_idx) == i) ? w_res_a : r_p3s[i];
                    r_p4_out[i*F_NBITS +: F_NBITS] <= (int'(r_idx) == i) ? w_res_b : r_p4s[i];
                  end else begin
                    r_p3_out[i*F_NBITS +: F_NBITS] <= '0;
                    r_p4_out[i*F_NBITS +: F_NBITS] <= '0;
                  end
                  if (!EARLY_EVEN) begin
                    r_even_out[i*F_NBITS +: F_NBITS] <= (i < int'(r_npairs)) ? r_tab[2*i]   : '0;
                    r_odd_out[i*F_NBITS +: F_NBITS]  <= (i < int'(r_npairs)) ? r_tab[2*i+1] : '0;
                  end
                end
                r_ben[BEN_PT3] <= 1'b1;
                r_ben[BEN_PT4] <= 1'b1;
                if (!EARLY_EVEN) begin
                  r_ben[BEN_EVEN] <= 1'b1;
                  r_ben[BEN_ODD]  <= 1'b1;
                end
              end else begin
                r_idx <= r_idx + ONE_I;
              end
            end
          end
          ST_WAITR: if (r_en) r_r <= r_in;
          ST_FOLD: begin
            if (w_pu_en) r_issued <= 1'b1;
            if (w_pu_vld) begin
              r_issued     <= 1'b0;
              r_tab[r_idx] <= w_res_a;
              if (w_last) begin
                r_idx    <= '0;
                r_round  <= w_round_nx;
                r_npairs <= r_npairs >> 1;
                if (w_round_nx == LAST_R) begin
                  // Table is now one scalar: expose it on even[0], everything else empty.
                  r_done     <= 1'b1;
                  r_even_out <= (F_NBITS*nCopiesH)'(w_res_a);
                  r_odd_out  <= '0;
                  r_p3_out   <= '0;
                  r_p4_out   <= '0;
                end else begin
                  r_first <= 1'b1;
                end
              end else begin
                r_idx <= r_idx + ONE_I;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign beta_en       = r_ben;
  assign beta_even_out = r_even_out;
  assign beta_odd_out  = r_odd_out;
  assign point3_out    = r_p3_out;
  assign point4_out    = r_p4_out;
  assign round         = r_round;
  assign ready         = w_ready;
  assign done          = r_done;

endmodule

// File: tb/tb_prover_compute_v_early_betafeed.sv
// Bench for the beta feeder at nCopyBits=2 against a modular-arithmetic table model.
module tb_prover_compute_v_early_betafeed;
  import prover_compute_v_early_betafeed_pkg::*;

  localparam int NB = 2;
  localparam int NC = 4;
  localparam int NH = 2;
  localparam int FN = 61;
  localparam bit [60:0]  Q61 = 61'h1FFF_FFFF_FFFF_FFFF;
  localparam bit [127:0] QM  = {67'd0, Q61};
`ifdef BETAFEED_EARLY_EVEN_EN
  localparam logic [3:0] EXP_BEN = 4'b1100;
  localparam bit EXP_EARLY = 1'b1;
`else
  localparam logic [3:0] EXP_BEN = 4'b1111;
  localparam bit EXP_EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstb, init_en, r_en;
  logic [FN*NC-1:0] beta_init;
  logic [FN-1:0] r_in;
  logic [3:0] beta_en;
  logic [FN*NH-1:0] beta_even_out, beta_odd_out, point3_out, point4_out;
  logic [1:0] round;
  logic ready, done;

  int total = 0;
  int bad = 0;

  prover_compute_v_early_betafeed #(.nCopyBits(NB)) dut (
    .clk(clk), .rstb(rstb), .init_en(init_en), .beta_init(beta_init),
    .r_en(r_en), .r_in(r_in), .beta_en(beta_en),
    .beta_even_out(beta_even_out), .beta_odd_out(beta_odd_out),
    .point3_out(point3_out), .point4_out(point4_out),
    .round(round), .ready(ready), .done(done)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit [60:0] mt [NC];
  int mact;

  function automatic bit [60:0] madd(bit [60:0] a, bit [60:0] b);
    bit [127:0] t;
    t = ({67'd0, a} + {67'd0, b}) % QM;
    return t[60:0];
  endfunction
  function automatic bit [60:0] msub(bit [60:0] a, bit [60:0] b);
    bit [127:0] t;
    t = ({67'd0, a} + QM - {67'd0, b}) % QM;
    return t[60:0];
  endfunction
  function automatic bit [60:0] mmul(bit [60:0] a, bit [60:0] b);
    bit [127:0] t;
    t = ({67'd0, a} * {67'd0, b}) % QM;
    return t[60:0];
  endfunction

  task automatic model_init(input logic [FN*NC-1:0] v);
    for (int i = 0; i < NC; i++) mt[i] = v[i*FN +: FN];
    mact = NC;
  endtask

  task automatic model_vecs(output logic [4*FN*NH-1:0] all);
    logic [FN*NH-1:0] e, o, p3, p4;
    bit [60:0] d, x3;
    e = '0; o = '0; p3 = '0; p4 = '0;
    for (int i = 0; i < mact/2; i++) begin
      d  = msub(mt[2*i+1], mt[2*i]);
      x3 = madd(mt[2*i+1], d);
      e[i*FN +: FN]  = mt[2*i];
      o[i*FN +: FN]  = mt[2*i+1];
      p3[i*FN +: FN] = x3;
      p4[i*FN +: FN] = madd(x3, d);
    end
    all = {e, o, p3, p4};
  endtask

  task automatic model_fold(input bit [60:0] r);
    bit [60:0] nt [NC];
    nt = mt;
    for (int i = 0; i < mact/2; i++) nt[i] = madd(mt[2*i], mmul(r, msub(mt[2*i+1], mt[2*i])));
    mt = nt;
    mact = mact / 2;
  endtask

  function automatic bit [60:0] rnd_fe();
    bit [127:0] t;
    case ($urandom_range(0, 3))
      0: return 61'd0;
      1: return Q61 - 61'd1;
      2: return 61'($urandom_range(0, 15));
      default: begin
        t = {64'd0, $urandom, $urandom} % QM;
        return t[60:0];
      end
    endcase
  endfunction

  function automatic logic [FN*NC-1:0] rnd_tab();
    logic [FN*NC-1:0] v;
    for (int i = 0; i < NC; i++) v[i*FN +: FN] = rnd_fe();
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_init(input logic [FN*NC-1:0] v);
    beta_init = v;
    init_en = 1'b1;
    tick();
    init_en = 1'b0;
  endtask

  task automatic send_r(input logic [FN-1:0] r);
    r_in = r;
    r_en = 1'b1;
    tick();
    r_en = 1'b0;
  endtask

  // Waits for the point strobe; reports timeout, early even/odd sighting, strobe value.
  task automatic wait_pts(output bit to, output bit early_seen, output logic [3:0] ben_at);
    to = 1'b1; early_seen = 1'b0; ben_at = 4'b0000;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (beta_en[BEN_PT3]) begin
        to = 1'b0;
        ben_at = beta_en;
        break;
      end
      if (beta_en[BEN_EVEN] && beta_en[BEN_ODD]) early_seen = 1'b1;
    end
  endtask

  task automatic wait_done(output bit to);
    to = 1'b1;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (done) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstb = 1'b1; init_en = 1'b0; r_en = 1'b0; r_in = '0; beta_init = '0;
    tick(); tick(); tick();
    total++;
    if ({beta_en, beta_even_out, beta_odd_out, point3_out, point4_out} !== '0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", {beta_en, beta_even_out});
    end
    total++;
    if ({round, ready, done} !== {2'd0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL reset_status got round=%0d ready=%b done=%b want 0/1/0", round, ready, done);
    end
    rstb = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    bit to, es; logic [3:0] ben;
    do_init({61'd4, 61'd3, 61'd2, 61'd1});
    wait_pts(to, es, ben);
    total++;
    if (to || ben !== EXP_BEN || es !== EXP_EARLY) begin
      bad++; $display("FAIL dir_strobe0 got to=%b ben=%b early=%b want ben=%b early=%b", to, ben, es, EXP_BEN, EXP_EARLY);
    end
    total++;
    if ({beta_even_out, beta_odd_out, point3_out, point4_out} !==
        {61'd3, 61'd1, 61'd4, 61'd2, 61'd5, 61'd3, 61'd6, 61'd4}) begin
      bad++; $display("FAIL dir_vec0 got e=%0d,%0d p3=%0d p4=%0d", beta_even_out[FN-1:0], beta_even_out[2*FN-1:FN], point3_out[FN-1:0], point4_out[FN-1:0]);
    end
    total++;
    if (ready !== 1'b1 || round !== 2'd0) begin
      bad++; $display("FAIL dir_ready0 got ready=%b round=%0d want 1/0", ready, round);
    end
    tick();
    total++;
    if (beta_en !== 4'b0000) begin
      bad++; $display("FAIL dir_strobe_width got=%b want=0000", beta_en);
    end
    send_r(61'd5);
    wait_pts(to, es, ben);
    total++;
    if (to || {beta_even_out, beta_odd_out, point3_out, point4_out} !==
        {61'd0, 61'd6, 61'd0, 61'd8, 61'd0, 61'd10, 61'd0, 61'd12} || round !== 2'd1) begin
      bad++; $display("FAIL dir_vec1 got to=%b e0=%0d o0=%0d p3=%0d p4=%0d round=%0d want 6/8/10/12 r1", to, beta_even_out[FN-1:0], beta_odd_out[FN-1:0], point3_out[FN-1:0], point4_out[FN-1:0], round);
    end
    send_r(61'd2);
    wait_done(to);
    total++;
    if (to || beta_even_out !== (FN*NH)'(10) || {beta_odd_out, point3_out, point4_out} !== '0) begin
      bad++; $display("FAIL dir_final got to=%b even=%h want=10", to, beta_even_out);
    end
    total++;
    if (round !== 2'd2 || ready !== 1'b1 || done !== 1'b1) begin
      bad++; $display("FAIL dir_done_status got round=%0d ready=%b done=%b want 2/1/1", round, ready, done);
    end
  endtask

  task automatic test_wrap();
    bit to, es; logic [3:0] ben;
    do_init({61'd7, 61'd7, 61'd2, 61'd5});
    wait_pts(to, es, ben);
    total++;
    if (to || point3_out[FN-1:0] !== Q61 - 61'd1 || point4_out[FN-1:0] !== Q61 - 61'd4) begin
      bad++; $display("FAIL wrap_pair0 got p3=%h p4=%h want %h %h", point3_out[FN-1:0], point4_out[FN-1:0], Q61 - 61'd1, Q61 - 61'd4);
    end
    total++;
    if (point3_out[2*FN-1:FN] !== 61'd7 || point4_out[2*FN-1:FN] !== 61'd7) begin
      bad++; $display("FAIL wrap_pair1 got p3=%0d p4=%0d want 7 7", point3_out[2*FN-1:FN], point4_out[2*FN-1:FN]);
    end
  endtask

  task automatic test_random();
    bit to, es; logic [3:0] ben; logic [4*FN*NH-1:0] exp;
    bit [60:0] r;
    for (int it = 0; it < 8; it++) begin
      beta_init = rnd_tab();
      model_init(beta_init);
      do_init(beta_init);
      for (int rd = 0; rd < NB; rd++) begin
        wait_pts(to, es, ben);
        model_vecs(exp);
        total++;
        if (to || ben !== EXP_BEN || {beta_even_out, beta_odd_out, point3_out, point4_out} !== exp || round !== 2'(rd)) begin
          bad++; $display("FAIL rand_round it=%0d rd=%0d to=%b round=%0d got=%h want=%h", it, rd, to, round, {beta_even_out, beta_odd_out, point3_out, point4_out}, exp);
        end
        for (int k = $urandom_range(0, 3); k > 0; k--) tick();
        r = rnd_fe();
        send_r(r);
        model_fold(r);
      end
      wait_done(to);
      total++;
      if (to || beta_even_out !== (FN*NH)'(mt[0]) || round !== 2'(NB)) begin
        bad++; $display("FAIL rand_final it=%0d to=%b got=%h want=%h round=%0d", it, to, beta_even_out, mt[0], round);
      end
    end
  endtask

  task automatic test_abort();
    bit to, es; logic [3:0] ben; logic [4*FN*NH-1:0] exp;
    logic [FN*NC-1:0] vb;
    do_init(rnd_tab());
    wait_pts(to, es, ben);
    send_r(61'd3);
    tick(); tick();
    vb = rnd_tab();
    model_init(vb);
    do_init(vb);
    wait_pts(to, es, ben);
    model_vecs(exp);
    total++;
    if (to || {beta_even_out, beta_odd_out, point3_out, point4_out} !== exp || round !== 2'd0) begin
      bad++; $display("FAIL abort_restart to=%b round=%0d got=%h want=%h", to, round, {beta_even_out, beta_odd_out, point3_out, point4_out}, exp);
    end
  endtask

  task automatic test_reset_mid();
    do_init(rnd_tab());
    tick(); tick(); tick();
    rstb = 1'b1;
    tick();
    total++;
    if ({beta_en, beta_even_out, beta_odd_out, point3_out, point4_out, round, done} !== '0 || ready !== 1'b1) begin
      bad++; $display("FAIL reset_mid got ben=%b round=%0d ready=%b done=%b e=%h", beta_en, round, ready, done, beta_even_out);
    end
    rstb = 1'b0;
    tick();
  endtask

  task automatic test_ignore_r();
    bit to, es; logic [3:0] ben; logic [4*FN*NH-1:0] exp;
    bit strobed;
    logic [FN*NC-1:0] v;
    send_r(61'd9);
    strobed = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (beta_en !== 4'b0000) strobed = 1'b1;
    end
    total++;
    if (strobed || round !== 2'd0 || ready !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL ignore_r_idle strobed=%b round=%0d ready=%b done=%b want 0/0/1/0", strobed, round, ready, done);
    end
    v = rnd_tab();
    model_init(v);
    do_init(v);
    tick();
    send_r(61'd11);
    wait_pts(to, es, ben);
    model_vecs(exp);
    total++;
    if (to || {beta_even_out, beta_odd_out, point3_out, point4_out} !== exp || round !== 2'd0) begin
      bad++; $display("FAIL ignore_r_pts to=%b round=%0d got=%h want=%h", to, round, {beta_even_out, beta_odd_out, point3_out, point4_out}, exp);
    end
    send_r(61'd4);
    model_fold(61'd4);
    wait_pts(to, es, ben);
    model_vecs(exp);
    total++;
    if (to || {beta_even_out, beta_odd_out, point3_out, point4_out} !== exp || round !== 2'd1) begin
      bad++; $display("FAIL ignore_r_fold1 to=%b round=%0d got=%h want=%h", to, round, {beta_even_out, beta_odd_out, point3_out, point4_out}, exp);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_wrap();
    test_random();
    test_abort();
    test_reset_mid();
    test_ignore_r();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
